// File: rtl/qdec_ctx_mem_pkg.sv
// ---------------------------------------------------------------------------
// qdec_cabac_package
// Shared types and constants for the CABAC decoder context-model storage.
//   CTX_NUM     number of context entries, also used by the context-init FSM
//               as its scan limit (CTX_NUM-1)
//   CTX_W       context entry width: {pStateIdx[5:0], valMps}
//   CTX_ADDR_W  context address width (unsigned)
//   t_state_mem bank-copy scan FSM states
// ---------------------------------------------------------------------------
package qdec_cabac_package;

  localparam int CTX_NUM    = 567;
  localparam int CTX_W      = 7;
  localparam int CTX_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE_MEM    = 2'd0,
    SAVE_MEM    = 2'd1,
    RESTORE_MEM = 2'd2,
    ENDING_MEM  = 2'd3
  } t_state_mem;

endpackage

// File: rtl/qdec_ctx_mem_if.sv
// ---------------------------------------------------------------------------
// qdec_ctx_mem_if
// Bundle of every non-clock signal of the context memory.
//   master : context-init FSM / bin decoder / WPP sync control side
//   slave  : qdec_ctx_mem
// Signals:
//   ctx_init_we/addr/wdata   init write burst
//   rd_req/rd_addr           decoder read request (taken when rd_ready=1)
//   rd_ready/rd_valid/rd_data read handshake and data
//   upd_we/addr/wdata        decoder state-update write
//   sync_save_start          pulse: copy main bank -> save bank
//   sync_restore_start       pulse: copy save bank -> main bank
//   sync_busy/sync_done_intr bank copy status
// ---------------------------------------------------------------------------
interface qdec_ctx_mem_if
  import qdec_cabac_package::*;
#(
  parameter int ADDR_W = CTX_ADDR_W,
  parameter int DW     = CTX_W
);

  logic              ctx_init_we;
  logic [ADDR_W-1:0] ctx_init_addr;
  logic [DW-1:0]     ctx_init_wdata;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;

  logic              upd_we;
  logic [ADDR_W-1:0] upd_addr;
  logic [DW-1:0]     upd_wdata;

  logic              sync_save_start;
  logic              sync_restore_start;
  logic              sync_busy;
  logic              sync_done_intr;

  modport master (
    output ctx_init_we, ctx_init_addr, ctx_init_wdata,
    output rd_req, rd_addr,
    input  rd_ready, rd_valid, rd_data,
    output upd_we, upd_addr, upd_wdata,
    output sync_save_start, sync_restore_start,
    input  sync_busy, sync_done_intr
  );

  modport slave (
    input  ctx_init_we, ctx_init_addr, ctx_init_wdata,
    input  rd_req, rd_addr,
    output rd_ready, rd_valid, rd_data,
    input  upd_we, upd_addr, upd_wdata,
    input  sync_save_start, sync_restore_start,
    output sync_busy, sync_done_intr
  );

endinterface

// File: rtl/qdec_ctx_mem_ctx_ram.sv
// ---------------------------------------------------------------------------
// qdec_ctx_ram
// Simple dual-port synchronous RAM: one write port, one registered read port
// with 1-cycle latency. A read and write to the same address in one cycle
// returns the old contents; callers handle forwarding. Contents are not reset.
// Callers only present in-range addresses.
// Ports:
//   clk                 clock
//   we, waddr, wdata    write port
//   re, raddr           read port; rdata updates only when re=1
//   rdata               registered read data
// ---------------------------------------------------------------------------
module qdec_ctx_ram
  import qdec_cabac_package::*;
#(
  parameter int DEPTH  = CTX_NUM,
  parameter int WIDTH  = CTX_W,
  parameter int ADDR_W = CTX_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/qdec_ctx_mem.sv
// ---------------------------------------------------------------------------
// qdec_ctx_mem
// CABAC context-model state storage. A main bank absorbs the context-init
// write burst and serves the bin decoder's read/update traffic; a save bank
// holds a WPP snapshot. Save/restore copies run as an internal scan, one
// entry per cycle, during which the decoder read port is closed.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    qdec_ctx_mem_if.slave (init write, read, update, sync control)
// Main-bank write priority: init write > update write > restore-copy write.
// Writes with address >= CTX_NUM are dropped; out-of-range reads return 0.
// ---------------------------------------------------------------------------
module qdec_ctx_mem
  import qdec_cabac_package::*;
#(
  parameter int CTX_NUM = qdec_cabac_package::CTX_NUM,
  parameter int CTX_W   = qdec_cabac_package::CTX_W,
  parameter int ADDR_W  = qdec_cabac_package::CTX_ADDR_W
) (
  input  logic           clk,
  input  logic           rst_n,
  qdec_ctx_mem_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CTX_NUM - 1);

  // Full-width unsigned compare, so e.g. 1023 never aliases a valid entry.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(CTX_NUM);
  endfunction

  t_state_mem        state_q, state_d;
  logic [ADDR_W-1:0] counter_scan;
  logic              copy_state;
  logic              scan_done;
  logic              scan_vld_p1;
  logic [ADDR_W-1:0] scan_addr_p1;
  logic              rd_ready_q;
  logic              done_q;
  logic              rd_fire;

  logic              main_sel_we;
  logic              main_we;
  logic [ADDR_W-1:0] main_waddr;
  logic [CTX_W-1:0]  main_wdata;
  logic              main_re;
  logic [ADDR_W-1:0] main_raddr;
  logic [CTX_W-1:0]  main_rdata;

  logic              save_we;
  logic              save_re;
  logic [CTX_W-1:0]  save_rdata;

  logic              vld_p1;
  logic              oor_p1;
  logic              byp_p1;
  logic [CTX_W-1:0]  byp_data_p1;
  logic [CTX_W-1:0]  rd_fresh;
  logic [CTX_W-1:0]  rd_hold_q;

  assign copy_state = (state_q == SAVE_MEM) || (state_q == RESTORE_MEM);
  // Last destination write (address CTX_NUM-1) ends the scan.
  assign scan_done  = scan_vld_p1 && (scan_addr_p1 == LAST_ADDR);
  assign rd_fire    = bus.rd_req && rd_ready_q;

  // -------------------------------------------------------------------------
  // Copy FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_MEM: begin
        if (bus.sync_save_start) begin
          state_d = SAVE_MEM;
        end else if (bus.sync_restore_start) begin
          state_d = RESTORE_MEM;
        end
      end
      SAVE_MEM, RESTORE_MEM: begin
        if (scan_done) begin
          state_d = ENDING_MEM;
        end
      end
      ENDING_MEM: begin
        state_d = IDLE_MEM;
      end
      default: begin
        state_d = IDLE_MEM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE_MEM;
      counter_scan <= '0;
      scan_vld_p1  <= 1'b0;
      rd_ready_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (copy_state) begin
        // Saturate on the last source address while its write drains.
        counter_scan <= (counter_scan == LAST_ADDR) ? counter_scan
                                                    : counter_scan + 1'b1;
      end else begin
        counter_scan <= '0;
      end
      scan_vld_p1 <= copy_state;
      rd_ready_q  <= (state_d == IDLE_MEM);
      done_q      <= (state_q == ENDING_MEM);
    end
  end

  // -------------------------------------------------------------------------
  // p0 -> p1: source read issued, destination write one cycle later
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    scan_addr_p1 <= counter_scan;
  end

  // Main-bank write arbitration; the restore write is lowest priority.
  always_comb begin
    main_sel_we = 1'b0;
    main_waddr  = '0;
    main_wdata  = '0;
    if (bus.ctx_init_we) begin
      main_sel_we = 1'b1;
      main_waddr  = bus.ctx_init_addr;
      main_wdata  = bus.ctx_init_wdata;
    end else if (bus.upd_we) begin
      main_sel_we = 1'b1;
      main_waddr  = bus.upd_addr;
      main_wdata  = bus.upd_wdata;
    end else if (scan_vld_p1 && (state_q == RESTORE_MEM)) begin
      main_sel_we = 1'b1;
      main_waddr  = scan_addr_p1;
      main_wdata  = save_rdata;
    end
  end

  assign main_we = main_sel_we && in_range(main_waddr);

  // Main read port is shared: scan source during save, decoder otherwise.
  // The decoder cannot fire during a save because rd_ready is low.
  assign main_re    = (state_q == SAVE_MEM) ||
                      (rd_fire && in_range(bus.rd_addr));
  assign main_raddr = (state_q == SAVE_MEM) ? counter_scan : bus.rd_addr;

  assign save_we = scan_vld_p1 && (state_q == SAVE_MEM);
  assign save_re = (state_q == RESTORE_MEM);

  qdec_ctx_ram #(
    .DEPTH  (CTX_NUM),
    .WIDTH  (CTX_W),
    .ADDR_W (ADDR_W)
  ) u_main_ram (
    .clk   (clk),
    .we    (main_we),
    .waddr (main_waddr),
    .wdata (main_wdata),
    .re    (main_re),
    .raddr (main_raddr),
    .rdata (main_rdata)
  );

  qdec_ctx_ram #(
    .DEPTH  (CTX_NUM),
    .WIDTH  (CTX_W),
    .ADDR_W (ADDR_W)
  ) u_save_ram (
    .clk   (clk),
    .we    (save_we),
    .waddr (scan_addr_p1),
    .wdata (main_rdata),
    .re    (save_re),
    .raddr (counter_scan),
    .rdata (save_rdata)
  );

  // -------------------------------------------------------------------------
  // p0 -> p1: decoder read request registered alongside RAM read
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      oor_p1      <= !in_range(bus.rd_addr);
      byp_p1      <= main_we && (main_waddr == bus.rd_addr);
      byp_data_p1 <= main_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      vld_p1 <= rd_fire;
      if (vld_p1) begin
        rd_hold_q <= rd_fresh;
      end
    end
  end

  // A same-cycle write to the read address wins over the stale RAM word.
  assign rd_fresh = oor_p1 ? '0 : (byp_p1 ? byp_data_p1 : main_rdata);

  assign bus.rd_data        = vld_p1 ? rd_fresh : rd_hold_q;
  assign bus.rd_valid       = vld_p1;
  assign bus.rd_ready       = rd_ready_q;
  assign bus.sync_busy      = (state_q != IDLE_MEM);
  assign bus.sync_done_intr = done_q;

endmodule

// File: tb/tb_qdec_ctx_mem.sv
// ---------------------------------------------------------------------------
// tb_qdec_ctx_mem
// Directed and randomized stimulus for qdec_ctx_mem against an array model
// of the two context banks.
// ---------------------------------------------------------------------------
module tb_qdec_ctx_mem;
  import qdec_cabac_package::*;

  localparam int N = CTX_NUM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qdec_ctx_mem_if bus ();

  qdec_ctx_mem dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] main_m [N];
  logic [6:0] save_m [N];
  logic [6:0] last_rd = '0;
  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] ref_rd(input logic [9:0] a);
    return (int'(a) < N) ? main_m[a] : 7'd0;
  endfunction

  // mode 0: k mod 128, mode 1: constant c, mode 2: random
  task automatic init_all(input int mode, input logic [6:0] c);
    for (int k = 0; k < N; k++) begin
      logic [6:0] d;
      d = (mode == 0) ? 7'(k % 128) : ((mode == 1) ? c : 7'($urandom));
      bus.ctx_init_we    = 1'b1;
      bus.ctx_init_addr  = 10'(k);
      bus.ctx_init_wdata = d;
      main_m[k] = d;
      step();
    end
    bus.ctx_init_we = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, input string tag);
    logic [6:0] e;
    e = ref_rd(a);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    step();
    bus.rd_req = 1'b0;
    last_rd = e;
    chk({tag, ".vld"}, 32'(bus.rd_valid), 32'd1);
    chk({tag, ".data"}, 32'(bus.rd_data), 32'(e));
  endtask

  // Back-to-back read of every entry; one comparison on the mismatch count.
  task automatic sweep(input string tag);
    int bad = 0;
    for (int k = 0; k < N; k++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 10'(k);
      step();
      if (!bus.rd_valid || bus.rd_data !== main_m[k]) bad++;
      last_rd = main_m[k];
    end
    bus.rd_req = 1'b0;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic pulse(input logic sv, input logic rs);
    bus.sync_save_start    = sv;
    bus.sync_restore_start = rs;
    step();
    bus.sync_save_start    = 1'b0;
    bus.sync_restore_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      step();
      if (bus.sync_done_intr) seen = 1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic upd(input logic [9:0] a, input logic [6:0] d);
    bus.upd_we    = 1'b1;
    bus.upd_addr  = a;
    bus.upd_wdata = d;
    if (int'(a) < N) main_m[a] = d;
    step();
    bus.upd_we = 1'b0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'd0);
    chk({tag, ".rd_ready"}, 32'(bus.rd_ready), 32'd0);
    chk({tag, ".busy"}, 32'(bus.sync_busy), 32'd0);
    chk({tag, ".done"}, 32'(bus.sync_done_intr), 32'd0);
  endtask

  initial begin
    bus.ctx_init_we        = 1'b0;
    bus.ctx_init_addr      = '0;
    bus.ctx_init_wdata     = '0;
    bus.rd_req             = 1'b0;
    bus.rd_addr            = '0;
    bus.upd_we             = 1'b0;
    bus.upd_addr           = '0;
    bus.upd_wdata          = '0;
    bus.sync_save_start    = 1'b0;
    bus.sync_restore_start = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("rel.rd_ready_pre_clk", 32'(bus.rd_ready), 32'd0);
    step();
    chk("rel.rd_ready", 32'(bus.rd_ready), 32'd1);

    // Init burst then reads
    init_all(0, 7'd0);
    do_read(10'd0, "init.rd0");
    do_read(10'd300, "init.rd300");
    chk("init.rd300.const", 32'(bus.rd_data), 32'd44);
    do_read(10'd566, "init.rd566");
    chk("init.rd566.const", 32'(bus.rd_data), 32'd54);
    step();
    chk("idle.vld", 32'(bus.rd_valid), 32'd0);
    chk("idle.hold", 32'(bus.rd_data), 32'd54);

    // Out-of-range reads and writes
    do_read(10'd567, "oor.rd567");
    do_read(10'd1023, "oor.rd1023");
    upd(10'd567, 7'h11);
    upd(10'd1023, 7'h22);
    do_read(10'd566, "oor.nowrap566");

    // Bypass
    bus.upd_we = 1'b1; bus.upd_addr = 10'd12; bus.upd_wdata = 7'h55;
    bus.rd_req = 1'b1; bus.rd_addr = 10'd12;
    main_m[12] = 7'h55;
    step();
    bus.upd_we = 1'b0; bus.rd_req = 1'b0;
    chk("byp.vld", 32'(bus.rd_valid), 32'd1);
    chk("byp.data", 32'(bus.rd_data), 32'h55);
    step();
    do_read(10'd12, "byp.reread");

    // Write priority: init beats update, bypass returns init data
    bus.ctx_init_we = 1'b1; bus.ctx_init_addr = 10'd20; bus.ctx_init_wdata = 7'h2A;
    bus.upd_we = 1'b1; bus.upd_addr = 10'd20; bus.upd_wdata = 7'h3B;
    bus.rd_req = 1'b1; bus.rd_addr = 10'd20;
    main_m[20] = 7'h2A;
    step();
    bus.ctx_init_we = 1'b0; bus.upd_we = 1'b0; bus.rd_req = 1'b0;
    chk("prio.byp", 32'(bus.rd_data), 32'h2A);
    do_read(10'd20, "prio.reread");

    // Randomized read/update traffic
    for (int i = 0; i < 300; i++) begin
      logic [9:0] ra, ua;
      logic [6:0] ud;
      logic rq, uw;
      rq = ($urandom_range(0, 3) != 0);
      uw = 1'($urandom_range(0, 1));
      ra = 10'($urandom_range(0, 620));
      ua = ($urandom_range(0, 3) == 0) ? ra : 10'($urandom_range(0, 620));
      ud = 7'($urandom);
      if (rq) begin
        if (int'(ra) >= N) last_rd = 7'd0;
        else if (uw && ua == ra) last_rd = ud;
        else last_rd = main_m[ra];
      end
      if (uw && int'(ua) < N) main_m[ua] = ud;
      bus.rd_req = rq; bus.rd_addr = ra;
      bus.upd_we = uw; bus.upd_addr = ua; bus.upd_wdata = ud;
      step();
      chk("rand.vld", 32'(bus.rd_valid), 32'(rq));
      chk("rand.data", 32'(bus.rd_data), 32'(last_rd));
    end
    bus.rd_req = 1'b0; bus.upd_we = 1'b0;

    // Save with copy timing; a restore pulse mid-copy must be ignored
    init_all(1, 7'h10);
    begin
      int bad = 0;
      pulse(1'b1, 1'b0);
      for (int k = 1; k <= 569; k++) begin
        if (!bus.sync_busy || bus.rd_ready || bus.sync_done_intr) bad++;
        if (k == 100) pulse(1'b0, 1'b1);
        else step();
      end
      chk("time.busy_window", 32'(bad), 32'd0);
      chk("time.done", 32'(bus.sync_done_intr), 32'd1);
      chk("time.ready", 32'(bus.rd_ready), 32'd1);
      chk("time.busy_end", 32'(bus.sync_busy), 32'd0);
      step();
      chk("time.done_pulse", 32'(bus.sync_done_intr), 32'd0);
      chk("time.restore_ignored", 32'(bus.sync_busy), 32'd0);
    end
    save_m = main_m;
    upd(10'd5, 7'h7F);
    do_read(10'd5, "sr.overwrite");
    pulse(1'b0, 1'b1);
    wait_done(700, "sr.restore_done");
    main_m = save_m;
    do_read(10'd5, "sr.restored");

    // Simultaneous start: save wins
    init_all(2, 7'd0);
    pulse(1'b1, 1'b1);
    chk("sim.busy", 32'(bus.sync_busy), 32'd1);
    wait_done(700, "sim.save_done");
    save_m = main_m;
    sweep("sim.main_unchanged");
    for (int i = 0; i < 20; i++) upd(10'($urandom_range(0, N - 1)), 7'($urandom));
    pulse(1'b0, 1'b1);
    wait_done(700, "sim.restore_done");
    main_m = save_m;
    sweep("sim.restored_all");

    // Reset mid-copy
    pulse(1'b1, 1'b0);
    repeat (199) step();
    chk("rstcopy.busy_before", 32'(bus.sync_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("rstcopy");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rstcopy.ready_pre_clk", 32'(bus.rd_ready), 32'd0);
    step();
    chk("rstcopy.ready", 32'(bus.rd_ready), 32'd1);
    begin
      int dones = 0;
      for (int i = 0; i < 600; i++) begin
        step();
        if (bus.sync_done_intr || bus.sync_busy) dones++;
      end
      chk("rstcopy.no_done", 32'(dones), 32'd0);
    end
    sweep("rstcopy.main_kept");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qdec_ctx_mem.md
Name: qdec_ctx_mem

Overview:
- Context-model state storage for the CABAC decoder.
- Sits directly downstream of the context-initialization FSM and absorbs its 567-entry write burst. Serves the bin decoder's per-bin read/update traffic.
- Keeps a second bank used for WPP save/restore. Copying between banks runs as an internal scan FSM.

Parameters:
- CTX_NUM, 567, number of context entries; valid addresses are 0..CTX_NUM-1.
- CTX_W, 7, entry width: {pStateIdx[5:0], valMps}.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ctx_init_we  input  1  init write strobe from the context-init FSM.
- ctx_init_addr  input  10  init write address.
- ctx_init_wdata  input  7  init write data.
- rd_req  input  1  decoder read request; accepted only when rd_ready=1.
- rd_addr  input  10  decoder read address.
- rd_ready  output  1  read port available (low while a bank copy runs).
- rd_valid  output  1  read data valid.
- rd_data  output  7  read data.
- upd_we  input  1  decoder state-update write strobe.
- upd_addr  input  10  update address.
- upd_wdata  input  7  updated state.
- sync_save_start  input  1  one-cycle pulse: copy main bank to save bank.
- sync_restore_start  input  1  one-cycle pulse: copy save bank to main bank.
- sync_busy  output  1  bank copy in progress.
- sync_done_intr  output  1  one-cycle pulse when a copy completes.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE_MEM; the copy counter clears to 0.
  - rd_valid, rd_data, rd_ready, sync_busy and sync_done_intr all clear to 0. rd_ready rises to 1 on the first clock after reset release.
  - RAM contents are not reset; software must re-init before decoding.
  - Reset asserted mid-copy aborts the copy and produces no done pulse.
- Main-bank write priority, highest first: ctx_init_we, then upd_we, then the restore-copy write.
  - A lower-priority write in the same cycle is dropped; the verification environment flags it as a protocol error.
  - Any write with address >= CTX_NUM is ignored.
- Read path:
  - rd_req && rd_ready in cycle N gives rd_valid=1 with rd_data in cycle N+1. rd_valid is low otherwise, and rd_data holds its last value.
  - Bypass: if a main-bank write to the same address occurs in cycle N, rd_data returns the new write data, not the stale RAM data.
  - An out-of-range rd_addr returns rd_data=0 with rd_valid=1.
- FSM states IDLE_MEM, SAVE_MEM, RESTORE_MEM, ENDING_MEM.
  - IDLE_MEM goes to SAVE_MEM on sync_save_start, else to RESTORE_MEM on sync_restore_start. If both pulse in the same cycle, save wins and the restore is dropped.
  - Start pulses are ignored outside IDLE_MEM.
  - SAVE_MEM / RESTORE_MEM go to ENDING_MEM when the scan is done.
  - ENDING_MEM goes to IDLE_MEM.
- Copy scan:
  - counter_scan runs 0..CTX_NUM-1, one source read per cycle, and saturates at CTX_NUM-1.
  - Each destination write happens one cycle after its source read, at the same address.
  - Scan is done in the cycle the last write (address 566) occurs.
- Copy timing:
  - sync_busy=1 from the cycle after the start pulse through the ENDING_MEM cycle, which is 569 cycles total.
  - rd_ready=!sync_busy. An upd_we during busy is still honoured on the main bank, but a decoder must not issue one.
  - sync_done_intr is a registered pulse that is high exactly one cycle, in the cycle after ENDING_MEM.
- Memories: two CTX_NUM x CTX_W arrays, each with 1 read port and 1 write port, synchronous read with 1-cycle latency.
- Width rules: addresses are unsigned 10-bit. The compare against CTX_NUM uses the full 10 bits, with no wrap.

Decomposition:
- qdec_cabac_package:
  - add enum t_state_mem {IDLE_MEM, SAVE_MEM, RESTORE_MEM, ENDING_MEM};
  - add localparam CTX_NUM=567 (shared with the context-init FSM, whose scan limit is CTX_NUM-1).
- Sub-module qdec_ctx_ram: a parameterized simple dual-port synchronous RAM (write port, registered read port), instantiated twice (main, save).

Test Plan:
- Init then read: write addr k with data (k mod 128) for k=0..566 via ctx_init_we, then read addr 0, 300, 566 -> rd_valid in the next cycle, with rd_data=0, 44, 54.
- Bypass: upd_we addr 12 data 7'h55 in the same cycle as rd_req addr 12 -> next cycle rd_data=7'h55. A read of addr 12 two cycles later also gives 7'h55.
- Save/restore: init all entries to 7'h10, pulse save, overwrite addr 5 with 7'h7F via upd_we, pulse restore, then read addr 5 -> 7'h10.
- Copy timing: sync_save_start at cycle T -> sync_busy and rd_ready=0 over T+1..T+569, sync_done_intr only at T+570, rd_ready=1 at T+570. A restore pulse at T+100 is ignored.
- Simultaneous start: save and restore pulsed together -> SAVE_MEM entered; save bank equals the main bank and the main bank is unchanged.
- Reset mid-copy: assert rst_n=0 at T+200 -> all outputs 0 immediately with no sync_done_intr. After release, rd_ready=1 one cycle later.
